// File: rtl/bn_scan_muxer_pkg.sv
// Shared definitions for the scan-muxer family: mode encodings, FSM state
// encoding and the width helper used to size select / channel-index ports.
// Latency: n/a (definitions only). Backpressure: n/a.
package bn_scan_muxer_pkg;

  // mode input encoding
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SCAN  = 1'b1;

  // Output stage occupancy: EMPTY has nothing to offer, FULL holds a sample.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Ceiling log2, used to derive the select width from the channel count.
  // Callers guarantee v >= 2, so the result is at least 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bn_scan_muxer_rr_next_channel.sv
// Round-robin successor search: first enabled channel after ptr, wrapping.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: en (enable mask), ptr (last served channel) -> found, next.
module rr_next_channel #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic [N-1:0]  en,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] next
);

  int c;

  // Walk the candidates from farthest (ptr itself, offset N) down to the
  // nearest (ptr+1). The last hit written wins, so the nearest enabled
  // channel after ptr is the one left on next. Offset N revisits ptr, which
  // is how a single enabled channel keeps getting served.
  always_comb begin
    found = 1'b0;
    next  = ptr;
    c     = 0;
    for (int i = N; i >= 1; i--) begin
      c = (int'(ptr) + i) % N;
      if (en[c]) begin
        found = 1'b1;
        next  = SW'(c);
      end
    end
  end

endmodule

// File: rtl/bn_scan_muxer.sv
// Registered N:1 channel muxer, fixed-select or round-robin scan over enabled channels.
// Latency: 1 cycle from sampled inputs to z/z_ch/valid; full rate with no bubbles.
// Backpressure: while valid & ~ready the sample is frozen and all inputs are ignored.
//
// Ports: clock/reset_ (async active-low); x packed channel data (channel k at
// x[k*W +: W]); b fixed-mode select; mode (0 fixed, 1 scan); en scan enable
// mask; z/z_ch registered sample and its source channel; valid/ready output
// handshake; err sticky flag for a fixed-mode select that names no channel.
module bn_scan_muxer
  import bn_scan_muxer_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8,
  localparam int SW = clog2(N)
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic [N*W-1:0] x,
  input  logic [SW-1:0]  b,
  input  logic           mode,
  input  logic [N-1:0]   en,
  output logic [W-1:0]   z,
  output logic [SW-1:0]  z_ch,
  output logic           valid,
  input  logic           ready,
  output logic           err
);

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
  // ptr resets to the last channel so the first scan starts at channel 0.
  localparam logic [SW-1:0] PTR_RST = SW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] ptr;

  logic          xfer;
  logic          load_slot;
  logic          b_in_range;
  logic          rr_found;
  logic [SW-1:0] rr_next;
  logic          cand_vld;
  logic [SW-1:0] cand_idx;
  logic [W-1:0]  cand_dat;
  logic          load_dat;
  logic          ptr_upd;
  logic          set_err;

  rr_next_channel #(
    .N  (N),
    .SW (SW)
  ) u_rr (
    .en    (en),
    .ptr   (ptr),
    .found (rr_found),
    .next  (rr_next)
  );

  // A new sample may be taken when the stage is empty or is draining this
  // cycle; the drain-and-refill case is what gives back-to-back throughput.
  assign xfer       = (state == ST_FULL) & ready;
  assign load_slot  = (state == ST_EMPTY) | xfer;
  assign b_in_range = ({1'b0, b} < N_EXT);

  // Candidate channel for the current load slot.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    if (mode == MODE_SCAN) begin
      cand_vld = rr_found;
      cand_idx = rr_next;
    end else begin
      cand_vld = b_in_range;
      cand_idx = b;
    end
  end

  // W-bit N-way data selection, written as an AND-OR search so a candidate
  // index beyond N-1 (non power-of-two N) simply selects nothing.
  always_comb begin
    cand_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (cand_idx == SW'(k)) begin
        cand_dat = x[k*W +: W];
      end
    end
  end

  assign load_dat = load_slot & cand_vld;
  assign ptr_upd  = load_slot & (mode == MODE_SCAN) & rr_found;
  assign set_err  = load_slot & (mode == MODE_FIXED) & ~b_in_range;

  // FSM: state register
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state. Outside a load slot the stage is FULL and stalled.
  always_comb begin
    state_nxt = state;
    if (load_slot) begin
      state_nxt = cand_vld ? ST_FULL : ST_EMPTY;
    end
  end

  // FSM: outputs (decoded straight from the state flop)
  always_comb begin
    valid = (state == ST_FULL);
  end

  // Output sample and source index. Left untouched when a load slot finds no
  // candidate, so z/z_ch keep showing the last sample while valid is low.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      z    <= '0;
      z_ch <= '0;
    end else if (load_dat) begin
      z    <= cand_dat;
      z_ch <= cand_idx;
    end
  end

  // Round-robin position; only scan loads move it, so fixed-mode periods
  // resume the scan where it left off.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ptr <= PTR_RST;
    end else if (ptr_upd) begin
      ptr <= rr_next;
    end
  end

  // Sticky select error; only reset clears it.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      err <= 1'b0;
    end else if (set_err) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bn_scan_muxer.sv
// Directed bench for bn_scan_muxer: a table of single-cycle vectors on an
// N=8 instance plus hand sequences for async reset, stall and an N=6 instance.
// Outputs are sampled 1 time unit after the rising edge.
module tb_bn_scan_muxer;

  logic clock;
  logic reset_;

  // N=8 instance
  logic [63:0] x8;
  logic [2:0]  b8;
  logic        mode8;
  logic [7:0]  en8;
  logic [7:0]  z8;
  logic [2:0]  z_ch8;
  logic        valid8;
  logic        ready8;
  logic        err8;

  // N=6 instance
  logic [47:0] x6;
  logic [2:0]  b6;
  logic        mode6;
  logic [5:0]  en6;
  logic [7:0]  z6;
  logic [2:0]  z_ch6;
  logic        valid6;
  logic        ready6;
  logic        err6;

  int checks;
  int errors;

  bn_scan_muxer #(.N(8), .W(8)) u8 (
    .clock  (clock),
    .reset_ (reset_),
    .x      (x8),
    .b      (b8),
    .mode   (mode8),
    .en     (en8),
    .z      (z8),
    .z_ch   (z_ch8),
    .valid  (valid8),
    .ready  (ready8),
    .err    (err8)
  );

  bn_scan_muxer #(.N(6), .W(8)) u6 (
    .clock  (clock),
    .reset_ (reset_),
    .x      (x6),
    .b      (b6),
    .mode   (mode6),
    .en     (en6),
    .z      (z6),
    .z_ch   (z_ch6),
    .valid  (valid6),
    .ready  (ready6),
    .err    (err6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       mode;
    logic [2:0] b;
    logic [7:0] en;
    logic       rdy;
    logic       ev;
    logic [2:0] ech;
    logic [7:0] ez;
  } vec_t;

  vec_t vt[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk8(input string tag, input logic ev, input logic [2:0] ech, input logic [7:0] ez);
    chk({tag, ".valid"}, {31'd0, valid8}, {31'd0, ev});
    chk({tag, ".z_ch"},  {29'd0, z_ch8},  {29'd0, ech});
    chk({tag, ".z"},     {24'd0, z8},     {24'd0, ez});
  endtask

  task automatic chk6(input string tag, input logic ev, input logic [2:0] ech, input logic [7:0] ez, input logic eerr);
    chk({tag, ".valid6"}, {31'd0, valid6}, {31'd0, ev});
    chk({tag, ".z_ch6"},  {29'd0, z_ch6},  {29'd0, ech});
    chk({tag, ".z6"},     {24'd0, z6},     {24'd0, ez});
    chk({tag, ".err6"},   {31'd0, err6},   {31'd0, eerr});
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // channel k carries k*0x11
    x8 = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    x6 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};

    //            mode  b     en           rdy   valid ch    z
    vt[0]  = '{1'b0, 3'd3, 8'h00,       1'b1, 1'b1, 3'd3, 8'h33}; // fixed b=3
    vt[1]  = '{1'b0, 3'd3, 8'h00,       1'b1, 1'b1, 3'd3, 8'h33}; // reloads
    vt[2]  = '{1'b1, 3'd0, 8'b1010_0101, 1'b1, 1'b1, 3'd0, 8'h00}; // scan starts at 0
    vt[3]  = '{1'b1, 3'd0, 8'b1010_0101, 1'b1, 1'b1, 3'd2, 8'h22};
    vt[4]  = '{1'b1, 3'd0, 8'b1010_0101, 1'b1, 1'b1, 3'd5, 8'h55};
    vt[5]  = '{1'b1, 3'd0, 8'b1010_0101, 1'b1, 1'b1, 3'd7, 8'h77};
    vt[6]  = '{1'b1, 3'd0, 8'b1010_0101, 1'b1, 1'b1, 3'd0, 8'h00}; // wrap
    vt[7]  = '{1'b1, 3'd0, 8'b1010_0101, 1'b1, 1'b1, 3'd2, 8'h22};
    vt[8]  = '{1'b1, 3'd0, 8'hFF,       1'b0, 1'b1, 3'd2, 8'h22}; // stall
    vt[9]  = '{1'b0, 3'd6, 8'hFF,       1'b0, 1'b1, 3'd2, 8'h22}; // inputs ignored
    vt[10] = '{1'b1, 3'd0, 8'h00,       1'b0, 1'b1, 3'd2, 8'h22};
    vt[11] = '{1'b1, 3'd0, 8'hFF,       1'b0, 1'b1, 3'd2, 8'h22};
    vt[12] = '{1'b1, 3'd0, 8'hFF,       1'b1, 1'b1, 3'd3, 8'h33}; // resume
    vt[13] = '{1'b1, 3'd0, 8'hFF,       1'b1, 1'b1, 3'd4, 8'h44};
    vt[14] = '{1'b1, 3'd0, 8'h00,       1'b1, 1'b0, 3'd4, 8'h44}; // no candidate
    vt[15] = '{1'b1, 3'd0, 8'h00,       1'b1, 1'b0, 3'd4, 8'h44};
    vt[16] = '{1'b1, 3'd0, 8'b0100_0000, 1'b1, 1'b1, 3'd6, 8'h66}; // single channel
    vt[17] = '{1'b1, 3'd0, 8'b0100_0000, 1'b1, 1'b1, 3'd6, 8'h66};
    vt[18] = '{1'b0, 3'd1, 8'h00,       1'b0, 1'b1, 3'd6, 8'h66}; // mode change waits
    vt[19] = '{1'b0, 3'd1, 8'h00,       1'b1, 1'b1, 3'd1, 8'h11};
    vt[20] = '{1'b1, 3'd0, 8'hFF,       1'b1, 1'b1, 3'd7, 8'h77}; // ptr kept (6)
    vt[21] = '{1'b1, 3'd0, 8'hFF,       1'b1, 1'b1, 3'd0, 8'h00};

    // reset state
    reset_ = 1'b0;
    mode8 = 1'b0; b8 = 3'd3; en8 = 8'h00; ready8 = 1'b1;
    mode6 = 1'b0; b6 = 3'd0; en6 = 6'h00; ready6 = 1'b0;
    tick();
    tick();
    chk8("reset", 1'b0, 3'd0, 8'h00);
    chk("reset.err", {31'd0, err8}, 32'd0);
    chk6("reset6", 1'b0, 3'd0, 8'h00, 1'b0);
    reset_ = 1'b1;

    // table-driven single-cycle vectors
    for (int i = 0; i < 22; i++) begin
      mode8  = vt[i].mode;
      b8     = vt[i].b;
      en8    = vt[i].en;
      ready8 = vt[i].rdy;
      tick();
      chk8($sformatf("vec%0d", i), vt[i].ev, vt[i].ech, vt[i].ez);
      chk($sformatf("vec%0d.err", i), {31'd0, err8}, 32'd0);
    end

    // async reset while holding channel 5
    mode8 = 1'b1; en8 = 8'b0010_0000; ready8 = 1'b1;
    tick();
    chk8("pre_rst", 1'b1, 3'd5, 8'h55);
    #2;
    reset_ = 1'b0;
    #1;
    chk8("mid_rst", 1'b0, 3'd0, 8'h00);
    en8 = 8'hFF; ready8 = 1'b0;
    tick();
    reset_ = 1'b1;
    tick();
    chk8("post_rst", 1'b1, 3'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk8($sformatf("hold%0d", i), 1'b1, 3'd0, 8'h00);
    end
    ready8 = 1'b1;
    tick();
    chk8("adv1", 1'b1, 3'd1, 8'h11);
    tick();
    chk8("adv2", 1'b1, 3'd2, 8'h22);

    // N=6: scan wraps at 5, then out-of-range fixed select
    chk6("n6_hold", 1'b1, 3'd0, 8'h00, 1'b0);
    mode6 = 1'b1; en6 = 6'b10_0001; ready6 = 1'b1;
    tick();
    chk6("n6_scan0", 1'b1, 3'd0, 8'h00, 1'b0);
    tick();
    chk6("n6_scan1", 1'b1, 3'd5, 8'h55, 1'b0);
    tick();
    chk6("n6_scan2", 1'b1, 3'd0, 8'h00, 1'b0);
    mode6 = 1'b0; b6 = 3'd7;
    tick();
    chk6("n6_bad0", 1'b0, 3'd0, 8'h00, 1'b1);
    tick();
    chk6("n6_bad1", 1'b0, 3'd0, 8'h00, 1'b1);
    b6 = 3'd2;
    tick();
    chk6("n6_b2", 1'b1, 3'd2, 8'h22, 1'b1);
    b6 = 3'd5;
    tick();
    chk6("n6_b5", 1'b1, 3'd5, 8'h55, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
